// File: rtl/store_uart_pkg.sv
// rtl/store_uart_pkg.sv - shared types and frame constants for store_uart_tx
// STORE_UART_PARITY_EN selects the 11-bit even-parity frame.
package store_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic [31:0] DEFAULT_TX_ADDR = 32'h0000_0064;
  localparam int          DATA_BITS       = 8;

`ifdef STORE_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - synchronous FIFO with push/pop and full/empty flags
// Pointers carry one extra bit so full and empty differ only in the MSB.
module store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_uart_tx.sv
// rtl/store_uart_tx.sv - store-snooping UART transmitter (8N1, or 8E1 with STORE_UART_PARITY_EN)
// Bytes stored to TX_ADDR are queued and serialised onto tx, LSB first.
module store_uart_tx
  import store_uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = DEFAULT_TX_ADDR,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  uart_state_t   state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    fifo_rdata;
  logic          fifo_empty;
  logic          fifo_full;
  logic          wr_hit;
  logic          bit_end;
  logic          pop;
  logic          unused_wdata;

  assign wr_hit       = MemWrite && (DataAdr == TX_ADDR);
  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign unused_wdata = ^WriteData[31:8];
  assign full         = fifo_full;
  assign busy         = (state != IDLE) || !fifo_empty;

  // The FIFO refuses pushes while full, so a push racing a pop is dropped.
  store_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (reset),
    .push   (wr_hit),
    .wdata  (WriteData[7:0]),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 1'b0;
    else if (wr_hit && fifo_full) overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
`ifdef STORE_UART_PARITY_EN
      DATA:   if (bit_end && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY: if (bit_end) state_nxt = STOP;
`else
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:  if (bit_end) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STORE_UART_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   parity_bit <= 1'b0;
    else if (pop) parity_bit <= ^fifo_rdata;
  end
`endif

  // tx is decoded from state so an asserted reset forces it high at once.
  always_comb begin
    pop = 1'b0;
    tx  = 1'b1;
    case (state)
      IDLE:  pop = !fifo_empty;
      START: tx  = 1'b0;
      DATA:  tx  = shreg[0];
`ifdef STORE_UART_PARITY_EN
      PARITY: tx = parity_bit;
`endif
      STOP:  pop = bit_end && !fifo_empty;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
    end else begin
      if (pop || state == IDLE || bit_end) baud_cnt <= '0;
      else                                 baud_cnt <= baud_cnt + BW'(1);

      if (pop) begin
        shreg   <= fifo_rdata;
        bit_idx <= 3'd0;
      end else if (state == DATA && bit_end) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_store_uart_tx.sv
// tb/tb_store_uart_tx.sv - directed self-checking bench for store_uart_tx
// Add STORE_UART_PARITY_EN to the build to exercise the parity frame.
module tb_store_uart_tx;
  import store_uart_pkg::*;

  localparam int          CPB       = 4;
  localparam int          DEPTH     = 8;
  localparam int          FRAME_CYC = FRAME_BITS * CPB;
  localparam logic [31:0] TXA       = 32'h0000_0064;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        tx;
  logic        busy;
  logic        full;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic       r_act = 1'b0;
  int         r_cnt = 0;
  int         r_err = 0;
  logic [7:0] r_sh  = 8'd0;
  logic [7:0] rx_q[$];
  int         start_q[$];
  logic       par_q[$];

  store_uart_tx #(
    .TX_ADDR      (TXA),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial receiver: samples each bit mid-cell; start/stop errors are counted.
  always @(negedge clk) begin
    if (!reset) begin
      r_act <= 1'b0;
      r_cnt <= 0;
    end else if (!r_act) begin
      if (tx === 1'b0) begin
        r_act <= 1'b1;
        r_cnt <= 1;
        start_q.push_back(cyc);
      end
    end else begin
      r_cnt <= r_cnt + 1;
      if (r_cnt % CPB == CPB / 2) begin
        if (r_cnt / CPB == 0) begin
          if (tx !== 1'b0) r_err <= r_err + 1;
        end else if (r_cnt / CPB <= 8) begin
          r_sh <= {tx, r_sh[7:1]};
        end else if (r_cnt / CPB == FRAME_BITS - 1) begin
          if (tx !== 1'b1) r_err <= r_err + 1;
          rx_q.push_back(r_sh);
          r_act <= 1'b0;
        end else begin
          par_q.push_back(tx);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic we);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
    par_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget, input string nm);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (rx_q.size() < n) $display("FAIL %s: received %0d bytes, need %0d", nm, rx_q.size(), n);
    else n_pass++;
  endtask

  task automatic wait_start(input int budget, input string nm);
    int k = 0;
    while (start_q.size() == 0 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (start_q.size() == 0) $display("FAIL %s: no start bit within %0d cycles", nm, budget);
    else n_pass++;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s: busy=%b after %0d cycles, need 0", nm, busy, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b need 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b need 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b need 0", overflow); else n_pass++;
  endtask

  task automatic test_single();
    int e0;
    int f;
    clear_rx();
    e0 = cyc + 1;
    store(TXA, 32'h0000_0041, 1'b1);
    wait_start(10, "single_start");
    f = (start_q.size() > 0) ? start_q[0] : cyc;
    n_checks++; if (f !== e0 + 1) $display("FAIL single_latency: tx fell at edge %0d need %0d", f, e0 + 1); else n_pass++;
    wait_cyc(f + FRAME_CYC - 1);
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_stop: got %b need 1", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b need 0", busy); else n_pass++;
    wait_rx(1, 20, "single_rx");
    n_checks++; if (rx_q[0] !== 8'h41) $display("FAIL single_byte: got %h need 41", rx_q[0]); else n_pass++;
  endtask

  task automatic test_no_decode();
    clear_rx();
    store(32'h0000_0060, 32'h0000_0041, 1'b1);
    store(32'h0000_0068, 32'h0000_0042, 1'b1);
    store(TXA, 32'h0000_0043, 1'b0);
    store(32'h1000_0064, 32'h0000_0044, 1'b1);
    repeat (8) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL nodec_busy: got %b need 0", busy); else n_pass++;
    n_checks++; if (tx !== 1'b1) $display("FAIL nodec_tx: got %b need 1", tx); else n_pass++;
    n_checks++; if (start_q.size() !== 0) $display("FAIL nodec_frames: got %0d frames need 0", start_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h55;
    exp[1] = 8'hAA;
    exp[2] = 8'h0F;
    clear_rx();
    for (int i = 0; i < 3; i++) store(TXA, {24'h0, exp[i]}, 1'b1);
    wait_rx(3, 3 * FRAME_CYC + 20, "b2b_rx");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) $display("FAIL b2b_byte%0d: got %h need %h", i, rx_q[i], exp[i]); else n_pass++;
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (start_q[i] - start_q[i-1] !== FRAME_CYC)
        $display("FAIL b2b_gap%0d: start spacing %0d need %0d", i, start_q[i] - start_q[i-1], FRAME_CYC);
      else n_pass++;
    end
    wait_cyc(start_q[0] + 3 * FRAME_CYC - 1);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_last: got %b need 1", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_drop: got %b need 0", busy); else n_pass++;
  endtask

  task automatic test_overflow();
    int f;
    logic [7:0] e;
    clear_rx();
    store(TXA, 32'h0000_0011, 1'b1);
    wait_start(10, "ovf_start");
    f = (start_q.size() > 0) ? start_q[0] : cyc;
    for (int i = 0; i < 10; i++) begin
      store(TXA, 32'h20 + i, 1'b1);
      if (i == 6) begin
        n_checks++; if (full !== 1'b0) $display("FAIL ovf_full7: got %b need 0", full); else n_pass++;
      end
      if (i == 7) begin
        n_checks++; if (full !== 1'b1) $display("FAIL ovf_full8: got %b need 1", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b need 0", overflow); else n_pass++;
      end
      if (i == 8) begin
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b need 1", overflow); else n_pass++;
      end
    end
    // Store lands on the same edge as the end-of-stop pop.
    wait_cyc(f + FRAME_CYC - 1);
    store(TXA, 32'h0000_0077, 1'b1);
    n_checks++; if (full !== 1'b0) $display("FAIL ovf_pop_race_full: got %b need 0", full); else n_pass++;
    wait_rx(9, 9 * FRAME_CYC + 20, "ovf_rx");
    wait_idle(2 * FRAME_CYC, "ovf_idle");
    n_checks++; if (rx_q.size() !== 9) $display("FAIL ovf_count: got %0d bytes need 9", rx_q.size()); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      e = (i == 0) ? 8'h11 : 8'(32'h20 + i - 1);
      n_checks++;
      if (rx_q[i] !== e) $display("FAIL ovf_byte%0d: got %h need %h", i, rx_q[i], e); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b need 1", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int f;
    clear_rx();
    store(TXA, 32'h0000_00C3, 1'b1);
    store(TXA, 32'h0000_005A, 1'b1);
    store(TXA, 32'h0000_006B, 1'b1);
    wait_start(10, "rst_start");
    f = (start_q.size() > 0) ? start_q[0] : cyc;
    wait_cyc(f + 3 * CPB + 1);
    n_checks++; if (tx !== 1'b0) $display("FAIL rst_mid_bit2: got %b need 0", tx); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL rst_async_tx: got %b need 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b need 0", busy); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL rst_async_full: got %b need 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_async_ovf: got %b need 0", overflow); else n_pass++;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    clear_rx();
    repeat (2 * FRAME_CYC) tick();
    n_checks++; if (start_q.size() !== 0) $display("FAIL rst_no_frames: got %0d frames need 0", start_q.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy: got %b need 0", busy); else n_pass++;
    store(TXA, 32'h0000_003C, 1'b1);
    wait_rx(1, FRAME_CYC + 20, "rst_after_rx");
    wait_idle(FRAME_CYC, "rst_after_idle");
    n_checks++; if (rx_q[0] !== 8'h3C) $display("FAIL rst_after_byte: got %h need 3c", rx_q[0]); else n_pass++;
    n_checks++; if (rx_q.size() !== 1) $display("FAIL rst_after_count: got %0d need 1", rx_q.size()); else n_pass++;
  endtask

`ifdef STORE_UART_PARITY_EN
  task automatic test_parity();
    clear_rx();
    store(TXA, 32'h0000_0007, 1'b1);
    store(TXA, 32'h0000_0003, 1'b1);
    wait_rx(2, 2 * FRAME_CYC + 20, "par_rx");
    n_checks++; if (par_q[0] !== 1'b1) $display("FAIL par_07: got %b need 1", par_q[0]); else n_pass++;
    n_checks++; if (par_q[1] !== 1'b0) $display("FAIL par_03: got %b need 0", par_q[1]); else n_pass++;
    n_checks++; if (start_q[1] - start_q[0] !== 44) $display("FAIL par_len: got %0d need 44", start_q[1] - start_q[0]); else n_pass++;
    n_checks++; if (rx_q[1] !== 8'h03) $display("FAIL par_byte: got %h need 03", rx_q[1]); else n_pass++;
  endtask
`endif

  task automatic test_framing();
    n_checks++;
    if (r_err !== 0) $display("FAIL framing: %0d bad start/stop bits, need 0", r_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_decode();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef STORE_UART_PARITY_EN
    test_parity();
`endif
    test_framing();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
